// File: rtl/id_operand_stage.sv
// ID pipeline register and operand collector: holds {pc, inst} from IF,
// resolves rj/rk-or-rd operands from regfile or forwarding, hands a stable bundle to EX.
module id_operand_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             fs_to_ds_valid,
    input  logic [63:0]      fs_to_ds_bus,
    output logic             ds_allowin,
    output logic [4:0]       rf_raddr1,
    output logic [4:0]       rf_raddr2,
    input  logic [31:0]      rf_rdata1,
    input  logic [31:0]      rf_rdata2,
    input  logic             pause,
    input  logic             addr1_occur,
    input  logic [31:0]      addr1_forward,
    input  logic             addr2_occur,
    input  logic [31:0]      addr2_forward,
    input  logic             es_allowin,
    output logic             ds_to_es_valid,
    output logic [127:0]     ds_to_es_bus,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             r_ds_valid;
    logic [63:0]      r_ds_bus;
    logic             r_op_locked;
    logic [31:0]      r_lat1;
    logic [31:0]      r_lat2;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [31:0] w_inst;
    logic [4:0]  w_rj;
    logic [4:0]  w_rk;
    logic [4:0]  w_rd;
    logic        w_is_branch;
    logic        w_is_store;
    logic        w_src2_is_rd;
    logic [31:0] w_live1;
    logic [31:0] w_live2;
    logic [31:0] w_rj_value;
    logic [31:0] w_rkd_value;
    logic        w_ready_go;
    logic        w_accept;
    logic        w_lock_set;
    logic        w_stall;

    assign w_inst = r_ds_bus[31:0];
    assign w_rj   = w_inst[9:5];
    assign w_rk   = w_inst[14:10];
    assign w_rd   = w_inst[4:0];

    // Branches and stores read rd as their second source
    assign w_is_branch  = (w_inst[31:26] >= 6'h16) && (w_inst[31:26] <= 6'h1B);
    assign w_is_store   = (w_inst[31:22] >= 10'h0A4) && (w_inst[31:22] <= 10'h0A6);
    assign w_src2_is_rd = w_is_branch | w_is_store;

    // An empty stage presents r0 so the detector never stalls on stale fields
    assign rf_raddr1 = r_ds_valid ? w_rj : 5'd0;
    assign rf_raddr2 = r_ds_valid ? (w_src2_is_rd ? w_rd : w_rk) : 5'd0;

    assign w_live1 = addr1_occur ? addr1_forward : rf_rdata1;
    assign w_live2 = addr2_occur ? addr2_forward : rf_rdata2;

    assign w_rj_value  = r_op_locked ? r_lat1 : w_live1;
    assign w_rkd_value = r_op_locked ? r_lat2 : w_live2;

    assign w_ready_go     = r_op_locked | ~pause;
    assign ds_allowin     = ~r_ds_valid | (w_ready_go & es_allowin);
    assign ds_to_es_valid = r_ds_valid & w_ready_go & ~flush;
    assign ds_to_es_bus   = {r_ds_bus, w_rj_value, w_rkd_value};
    assign stall_cnt      = r_stall_cnt;

    assign w_accept   = ds_to_es_valid & es_allowin;
    assign w_lock_set = r_ds_valid & ~pause & ~r_op_locked
                      & ~es_allowin & ~flush;
    assign w_stall    = r_ds_valid & ~w_ready_go & ~flush;

    // Pipeline register: take a new instruction whenever the stage can accept
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ds_valid <= 1'b0;
            r_ds_bus   <= 64'd0;
        end else begin
            if (flush) begin
                r_ds_valid <= 1'b0;
            end else if (ds_allowin) begin
                r_ds_valid <= fs_to_ds_valid;
            end
            if (ds_allowin && fs_to_ds_valid && !flush) begin
                r_ds_bus <= fs_to_ds_bus;
            end
        end
    end

    // Freeze resolved operands while EX is blocked; forwarding sources may drain
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_op_locked <= 1'b0;
            r_lat1      <= 32'd0;
            r_lat2      <= 32'd0;
        end else if (flush || w_accept) begin
            r_op_locked <= 1'b0;
        end else if (w_lock_set) begin
            r_op_locked <= 1'b1;
            r_lat1      <= w_live1;
            r_lat2      <= w_live2;
        end
    end

    // Saturating count of cycles the held instruction waited on the detector
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
